elbeth_ras: RTL and testbench

- Return-address stack for the ELBETH fetch stage.
- On a call it pushes the link address (call PC + 4); on a return it pops and supplies the predicted return PC.
- It sits beside the PC-increment logic and is the consuming end of the link address that the fetch path produces.
- Circular buffer: on overflow the newest entry replaces the oldest and no stall is raised.

---
 rtl/elbeth_ras.sv | 123 ++++++++++++
 tb/tb_elbeth_ras.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_ras.sv
// Return-address stack for the ELBETH fetch stage: circular buffer of link addresses.
// Optional per-event statistics counters are enabled with `define ELBETH_RAS_STATS_EN.
module elbeth_ras #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [31:0]      push_pc_i,
    input  logic             pop_i,
`ifdef ELBETH_RAS_STATS_EN
    output logic [15:0]      push_cnt_o,
    output logic [15:0]      pop_cnt_o,
    output logic [15:0]      ovf_cnt_o,
`endif
    output logic [31:0]      top_o,
    output logic             top_valid_o,
    output logic [PTR_W:0]   count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] tos, tos_prev, next_tos;
    logic [PTR_W:0]   count, next_count;
    logic             next_ovf, next_unf;
    logic             we;
    logic [PTR_W-1:0] waddr;
    logic [31:0]      link;

    assign link     = push_pc_i + 32'd4;
    assign tos_prev = tos - PTR_ONE;

    assign top_valid_o = (count != '0);
    assign top_o       = top_valid_o ? mem[tos_prev] : 32'h0;
    assign count_o     = count;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        next_tos   = tos;
        next_count = count;
        next_ovf   = 1'b0;
        next_unf   = 1'b0;
        we         = 1'b0;
        waddr      = tos;
        if (flush_i) begin
            next_tos   = '0;
            next_count = '0;
        end else if (push_i && pop_i) begin
            we = 1'b1;
            if (count != '0) begin
                // Tail call: the return's slot is reused for the new link.
                waddr = tos_prev;
            end else begin
                next_tos   = tos + PTR_ONE;
                next_count = CNT_ONE;
            end
        end else if (push_i) begin
            we       = 1'b1;
            next_tos = tos + PTR_ONE;
            if (count == CNT_FULL) next_ovf = 1'b1;
            else                   next_count = count + CNT_ONE;
        end else if (pop_i) begin
            if (count != '0) begin
                next_tos   = tos_prev;
                next_count = count - CNT_ONE;
            end else begin
                next_unf = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos         <= '0;
            count       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            tos         <= next_tos;
            count       <= next_count;
            overflow_o  <= next_ovf;
            underflow_o <= next_unf;
        end
    end

    // NOTE: the entry array has no reset; liveness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= link;
    end

`ifdef ELBETH_RAS_STATS_EN
    logic push_acc, pop_ok;

    assign push_acc = !flush_i && push_i;
    assign pop_ok   = !flush_i && pop_i && !push_i && (count != '0);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Statistics survive flushes; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt_o <= '0;
            pop_cnt_o  <= '0;
            ovf_cnt_o  <= '0;
        end else begin
            if (push_acc) push_cnt_o <= sat_inc(push_cnt_o);
            if (pop_ok)   pop_cnt_o  <= sat_inc(pop_cnt_o);
            if (next_ovf) ovf_cnt_o  <= sat_inc(ovf_cnt_o);
        end
    end
`endif

endmodule

// File: tb/tb_elbeth_ras.sv
// Self-checking bench for elbeth_ras: queue-based reference model compared every cycle,
// plus directed literal checks. Define ELBETH_RAS_STATS_EN to also check the counters.
module tb_elbeth_ras;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i, push_i, pop_i;
    logic [31:0]      push_pc_i;
    logic [31:0]      top_o;
    logic             top_valid_o;
    logic [PTR_W:0]   count_o;
    logic             overflow_o, underflow_o;
`ifdef ELBETH_RAS_STATS_EN
    logic [15:0]      push_cnt_o, pop_cnt_o, ovf_cnt_o;
`endif

    elbeth_ras #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .push_i      (push_i),
        .push_pc_i   (push_pc_i),
        .pop_i       (pop_i),
`ifdef ELBETH_RAS_STATS_EN
        .push_cnt_o  (push_cnt_o),
        .pop_cnt_o   (pop_cnt_o),
        .ovf_cnt_o   (ovf_cnt_o),
`endif
        .top_o       (top_o),
        .top_valid_o (top_valid_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded stack held as a queue, newest entry at the back.
    logic [31:0] q[$];
    bit          m_ovf, m_unf;
    int          m_push_cnt, m_pop_cnt, m_ovf_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf = 0; m_unf = 0;
            m_push_cnt = 0; m_pop_cnt = 0; m_ovf_cnt = 0;
        end else begin
            m_ovf = 0; m_unf = 0;
            if (flush_i) begin
                q.delete();
            end else if (push_i && pop_i) begin
                if (q.size() > 0) q[q.size()-1] = push_pc_i + 32'd4;
                else              q.push_back(push_pc_i + 32'd4);
                m_push_cnt++;
            end else if (push_i) begin
                if (q.size() == DEPTH) begin
                    void'(q.pop_front());
                    m_ovf = 1;
                    m_ovf_cnt++;
                end
                q.push_back(push_pc_i + 32'd4);
                m_push_cnt++;
            end else if (pop_i) begin
                if (q.size() > 0) begin
                    void'(q.pop_back());
                    m_pop_cnt++;
                end else begin
                    m_unf = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("m_count", 32'(count_o), 32'(q.size()));
            check("m_valid", 32'(top_valid_o), 32'(q.size() != 0));
            check("m_top", top_o, (q.size() != 0) ? q[q.size()-1] : 32'h0);
            check("m_ovf", 32'(overflow_o), 32'(m_ovf));
            check("m_unf", 32'(underflow_o), 32'(m_unf));
`ifdef ELBETH_RAS_STATS_EN
            check("m_push_cnt", 32'(push_cnt_o), 32'(m_push_cnt));
            check("m_pop_cnt", 32'(pop_cnt_o), 32'(m_pop_cnt));
            check("m_ovf_cnt", 32'(ovf_cnt_o), 32'(m_ovf_cnt));
`endif
        end
    end

    // Drives one cycle of request starting at a falling edge; returns at the next falling edge.
    task automatic drive(input logic f, input logic pu, input logic [31:0] pc, input logic po);
        flush_i = f; push_i = pu; push_pc_i = pc; pop_i = po;
        @(negedge clk);
        flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; push_pc_i = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        check("rst_count", 32'(count_o), 32'd0);
        check("rst_valid", 32'(top_valid_o), 32'd0);
        check("rst_top", top_o, 32'h0);

        // Single push then pop.
        drive(0, 1, 32'h0000_0100, 0);
        check("push1_top", top_o, 32'h0000_0104);
        check("push1_valid", 32'(top_valid_o), 32'd1);
        check("push1_count", 32'(count_o), 32'd1);
        drive(0, 0, 32'h0, 1);
        check("pop1_count", 32'(count_o), 32'd0);
        check("pop1_valid", 32'(top_valid_o), 32'd0);
        check("pop1_top", top_o, 32'h0);

        // Nine pushes into an 8-deep stack: only the ninth overflows.
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 32'h1000 + 32'(i) * 32'h10, 0);
            check("fill_ovf", 32'(overflow_o), (i == 8) ? 32'd1 : 32'd0);
        end
        check("fill_count", 32'(count_o), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("drain_top", top_o, 32'h1084 - 32'(i) * 32'h10);
            drive(0, 0, 32'h0, 1);
            check("drain_unf", 32'(underflow_o), 32'd0);
        end
        drive(0, 0, 32'h0, 1);
        check("empty_pop_unf", 32'(underflow_o), 32'd1);
        check("empty_pop_count", 32'(count_o), 32'd0);

        // Tail call replaces the top entry.
        drive(0, 1, 32'h200, 0);
        drive(0, 1, 32'h300, 0);
        drive(0, 1, 32'h400, 1);
        check("tail_top", top_o, 32'h404);
        check("tail_count", 32'(count_o), 32'd2);
        drive(0, 0, 32'h0, 1);
        check("tail_pop_top", top_o, 32'h204);

        // Link address wraps modulo 2^32.
        drive(0, 1, 32'hFFFF_FFFC, 0);
        check("wrap_top", top_o, 32'h0);
        check("wrap_valid", 32'(top_valid_o), 32'd1);

        // Flush beats a simultaneous push.
        drive(0, 1, 32'h10, 0);
        drive(0, 1, 32'h20, 0);
        drive(0, 1, 32'h30, 0);
        drive(1, 1, 32'h40, 0);
        check("flush_count", 32'(count_o), 32'd0);
        check("flush_valid", 32'(top_valid_o), 32'd0);
        check("flush_ovf", 32'(overflow_o), 32'd0);
        check("flush_unf", 32'(underflow_o), 32'd0);

        // Asynchronous reset between clock edges.
        drive(0, 1, 32'h50, 0);
        drive(0, 1, 32'h60, 0);
        check("pre_arst_count", 32'(count_o), 32'd2);
        #2 rst_n = 1'b0;
        #1 check("arst_count", 32'(count_o), 32'd0);
        check("arst_valid", 32'(top_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ELBETH_RAS_STATS_EN
        for (int i = 0; i < 10; i++) drive(0, 1, 32'h8000 + 32'(i) * 4, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 32'h0, 1);
        drive(1, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 1);
        check("stats_unf", 32'(underflow_o), 32'd1);
        check("stats_push", 32'(push_cnt_o), 32'd10);
        check("stats_pop", 32'(pop_cnt_o), 32'd3);
        check("stats_ovf", 32'(ovf_cnt_o), 32'd2);
`endif

        // Randomized phases: push-heavy, pop-heavy, balanced.
        for (int phase = 0; phase < 3; phase++) begin
            int push_pct;
            int pop_pct;
            push_pct = (phase == 0) ? 75 : (phase == 1) ? 30 : 50;
            pop_pct  = (phase == 0) ? 30 : (phase == 1) ? 75 : 50;
            for (int i = 0; i < 600; i++) begin
                logic        f, pu, po;
                logic [31:0] pc;
                f  = ($urandom_range(0, 99) < 3);
                pu = ($urandom_range(0, 99) < push_pct);
                po = ($urandom_range(0, 99) < pop_pct);
                pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
                drive(f, pu, pc, po);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
